vga_line_fetch_ctrl: RTL and testbench

- Sequences framebuffer reads for the VGA player and feeds pixels to the output stage in step with VgaSyncGen.
- Reads a 160x120, 4 bpp source image from a byte-wide memory port into an internal ping-pong line buffer (2 x 80 bytes).
- Upscales by 2^SCALE_LOG2 in both axes to fill the 640x480 active area.
- Drives VgaSyncGen's data_done advance enable (timing_en), so it can stall timing when a fetch is late.

---
 rtl/vga_line_fetch_ctrl.sv | 218 +++++++++++++++++++++
 tb/tb_vga_line_fetch_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/vga_line_fetch_ctrl.sv
// Ping-pong line fetcher and 2^SCALE_LOG2 upscaler feeding pixels in step with VgaSyncGen.
// Define VGA_UNDERRUN_STALL_EN to stall timing on a late fetch instead of showing a stale line.
module vga_line_fetch_ctrl #(
    parameter int HTOTAL     = 832,
    parameter int VTOTAL     = 520,
    parameter int HBLANK     = 192,
    parameter int VBLANK     = 40,
    parameter int SRC_W      = 160,
    parameter int SRC_H      = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int AW         = 16,
    parameter int FB_BASE    = 0
) (
    input  logic          px_clk,
    input  logic          reset_n,
    input  logic          enable,
    input  logic [9:0]    hc,
    input  logic [9:0]    vc,
    output logic          timing_en,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_ack,
    input  logic [7:0]    mem_rdata,
    output logic [3:0]    pix,
    output logic          pix_active,
    output logic          underrun
);
    localparam int WPL = SRC_W / 2;
    localparam int WW  = $clog2(WPL);
    localparam int LW  = $clog2(SRC_H);
    localparam logic [9:0]    HLAST = 10'(HTOTAL - 1);
    localparam logic [9:0]    VLAST = 10'(VTOTAL - 1);
    localparam logic [9:0]    HBL   = 10'(HBLANK);
    localparam logic [9:0]    VBL   = 10'(VBLANK);
    localparam logic [9:0]    SMASK = 10'((1 << SCALE_LOG2) - 1);
    localparam logic [9:0]    NGRP  = 10'(SRC_H);
    localparam logic [9:0]    GLAST = 10'(SRC_H - 1);
    localparam logic [WW-1:0] WLAST = WW'(WPL - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_REQ = 2'd1, S_WAIT = 2'd2} state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] line_q, line_d, pend_line_q, pend_line_d, launch_line_s;
    logic [WW-1:0] word_q, word_d, bidx_s;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [3:0]    pix_q, pix_d;
    logic [7:0]    buf0_q [0:WPL-1];
    logic [7:0]    buf1_q [0:WPL-1];
    logic [7:0]    byte_s;
    logic [9:0]    v_next_s, vrel_s, next_grp_s, x_s;
    logic fetch_done_q, fetch_done_d, front_q, front_d, pend_q, pend_d;
    logic mem_req_q, mem_req_d, underrun_q, underrun_d, pix_active_q, pix_active_d;
    logic at_swap_s, te_s, swap_s, ack_s, done_eff_s, fs_launch_s, sw_launch_s, active_s;

    function automatic logic [AW-1:0] fetch_addr(input logic [LW-1:0] l, input logic [WW-1:0] w);
        return AW'(FB_BASE) + AW'(l) * AW'(WPL) + AW'(w);
    endfunction

    // Decode whether the line after this one starts a new source-line group
    always_comb begin
        v_next_s   = (vc == VLAST) ? 10'd0 : vc + 10'd1;
        vrel_s     = v_next_s - VBL;
        next_grp_s = vrel_s >> SCALE_LOG2;
        at_swap_s  = (hc == HLAST) && (v_next_s >= VBL) && ((vrel_s & SMASK) == 10'd0)
                     && (next_grp_s < NGRP);
        ack_s      = (state_q == S_WAIT) && mem_ack;
        done_eff_s = fetch_done_q || (ack_s && (word_q == WLAST));
    end

`ifdef VGA_UNDERRUN_STALL_EN
    logic stall_q;
    // Freeze timing at the swap point until the back buffer is complete
    always_comb begin
        if (enable && at_swap_s && (stall_q ? !fetch_done_q : !done_eff_s)) te_s = 1'b0;
        else te_s = 1'b1;
    end

    // Remember that we are already waiting, so release waits for the registered done
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) stall_q <= 1'b0;
        else          stall_q <= at_swap_s && !te_s;
    end
`else
    assign te_s = 1'b1;
`endif

    // Swap and launch events
    always_comb begin
        swap_s        = at_swap_s && te_s;
        fs_launch_s   = enable && te_s && (hc == 10'd0) && (vc == 10'd0);
        sw_launch_s   = enable && swap_s && (next_grp_s < GLAST);
        launch_line_s = sw_launch_s ? LW'(next_grp_s + 10'd1) : {LW{1'b0}};
    end

    // Fetch FSM next state; a launch arriving mid-fetch is queued until IDLE
    always_comb begin
        state_d      = state_q;
        line_d       = line_q;
        word_d       = word_q;
        fetch_done_d = fetch_done_q;
        pend_d       = pend_q;
        pend_line_d  = pend_line_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        front_d      = front_q;
        underrun_d   = underrun_q || (enable && at_swap_s && !done_eff_s);
        case (state_q)
            S_IDLE: begin
                if (enable && (fs_launch_s || sw_launch_s || pend_q)) begin
                    line_d       = (fs_launch_s || sw_launch_s) ? launch_line_s : pend_line_q;
                    word_d       = {WW{1'b0}};
                    fetch_done_d = 1'b0;
                    pend_d       = 1'b0;
                    state_d      = S_REQ;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                if (enable) begin
                    mem_req_d  = 1'b1;
                    mem_addr_d = fetch_addr(line_q, word_q);
                    state_d    = S_WAIT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!mem_ack) begin
                    state_d = S_WAIT;
                end else if (word_q == WLAST) begin
                    fetch_done_d = 1'b1;
                    mem_req_d    = 1'b0;
                    state_d      = S_IDLE;
                end else if (!enable) begin
                    mem_req_d = 1'b0;
                    state_d   = S_IDLE;
                end else begin
                    word_d     = word_q + WW'(1);
                    mem_addr_d = fetch_addr(line_q, word_q + WW'(1));
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = S_IDLE;
            end
        endcase
        if ((state_q != S_IDLE) && (fs_launch_s || sw_launch_s)) begin
            pend_d      = 1'b1;
            pend_line_d = launch_line_s;
        end else begin
            pend_line_d = pend_line_q;
        end
        if (swap_s) begin
            front_d      = ~front_q;
            fetch_done_d = 1'b0;
        end else begin
            front_d = front_q;
        end
    end

    // Pixel path: one cycle behind hc/vc, matching VgaSyncGen's registered coordinates
    always_comb begin
        active_s     = (hc >= HBL) && (vc >= VBL);
        x_s          = hc - HBL;
        bidx_s       = WW'(x_s >> (SCALE_LOG2 + 1));
        byte_s       = front_q ? buf1_q[bidx_s] : buf0_q[bidx_s];
        pix_active_d = active_s;
        if (active_s && enable) pix_d = x_s[SCALE_LOG2] ? byte_s[7:4] : byte_s[3:0];
        else                    pix_d = 4'd0;
    end

    // State and output registers
    always_ff @(posedge px_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            line_q       <= {LW{1'b0}};
            word_q       <= {WW{1'b0}};
            fetch_done_q <= 1'b0;
            front_q      <= 1'b0;
            pend_q       <= 1'b0;
            pend_line_q  <= {LW{1'b0}};
            mem_req_q    <= 1'b0;
            mem_addr_q   <= {AW{1'b0}};
            underrun_q   <= 1'b0;
            pix_q        <= 4'd0;
            pix_active_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            line_q       <= line_d;
            word_q       <= word_d;
            fetch_done_q <= fetch_done_d;
            front_q      <= front_d;
            pend_q       <= pend_d;
            pend_line_q  <= pend_line_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            underrun_q   <= underrun_d;
            pix_q        <= pix_d;
            pix_active_q <= pix_active_d;
        end
    end

    // Back-buffer write; contents need no reset since they are filled before display
    always_ff @(posedge px_clk) begin
        if (ack_s) begin
            if (front_q) buf0_q[word_q] <= mem_rdata;
            else         buf1_q[word_q] <= mem_rdata;
        end
    end

    assign timing_en  = te_s;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign pix        = pix_q;
    assign pix_active = pix_active_q;
    assign underrun   = underrun_q;
endmodule

// File: tb/tb_vga_line_fetch_ctrl.sv
// Self-checking bench for vga_line_fetch_ctrl: randomized framebuffer and memory latency,
// checked against a source-image pixel model and a line-sequential address model.
module tb_vga_line_fetch_ctrl;
    logic        px_clk = 1'b0;
    logic        reset_n, enable, mem_ack;
    logic [9:0]  hc, vc;
    logic [7:0]  mem_rdata;
    logic        timing_en, mem_req, pix_active, underrun;
    logic [15:0] mem_addr;
    logic [3:0]  pix;
    logic        timing_en_b, mem_req_b, pix_active_b, underrun_b;
    logic [15:0] mem_addr_b;
    logic [3:0]  pix_b;

    logic [7:0]  mem [0:65535];
    int          n_chk = 0, n_fail = 0;
    int          exp_line, exp_word, acks, wcnt;
    bit          slow, pix_chk;
    logic [15:0] last_addr;

    always #5 px_clk = ~px_clk;

    vga_line_fetch_ctrl dut (
        .px_clk(px_clk), .reset_n(reset_n), .enable(enable), .hc(hc), .vc(vc),
        .timing_en(timing_en), .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .pix(pix), .pix_active(pix_active), .underrun(underrun)
    );

    vga_line_fetch_ctrl #(.FB_BASE(16'hFFF0)) dut_b (
        .px_clk(px_clk), .reset_n(reset_n), .enable(enable), .hc(hc), .vc(vc),
        .timing_en(timing_en_b), .mem_req(mem_req_b), .mem_addr(mem_addr_b), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .pix(pix_b), .pix_active(pix_active_b), .underrun(underrun_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Displayed colour for a screen position: each source pixel covers 4x4 screen pixels,
    // two source pixels per byte (even pixel in the low nibble).
    function automatic logic [3:0] model_pix(input int v, input int h);
        int src_y, src_x;
        logic [7:0] b;
        src_y = (v - 40) / 4;
        src_x = (h - 192) / 4;
        b = mem[src_y * 80 + src_x / 2];
        return (src_x % 2 == 1) ? b[7:4] : b[3:0];
    endfunction

    task automatic tick();
        int hp, vp;
        bit ep, tp, act;
        hp = int'(hc); vp = int'(vc); ep = enable; tp = timing_en;
        @(posedge px_clk); #1;
        if (tp) begin
            if (hc == 10'd831) begin
                hc = 10'd0;
                vc = (vc == 10'd519) ? 10'd0 : vc + 10'd1;
            end else begin
                hc = hc + 10'd1;
            end
        end
        act = (hp >= 192) && (vp >= 40);
        chk("pix_active", {31'd0, pix_active}, {31'd0, act});
        if (!act || !ep) chk("pix_blank", {28'd0, pix}, 32'd0);
        else if (pix_chk) chk("pix", {28'd0, pix}, {28'd0, model_pix(vp, hp)});
        if (mem_ack) begin
            mem_ack = 1'b0;
            acks++;
            wcnt = -1;
        end else if (mem_req) begin
            if (wcnt < 0) wcnt = slow ? 100 : int'($urandom_range(2, 0));
            if (wcnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = mem[mem_addr];
                chk("addr", {16'd0, mem_addr}, {16'd0, 16'(exp_line * 80 + exp_word)});
                chk("addr_base", {16'd0, mem_addr_b}, {16'd0, 16'(32'hFFF0 + exp_line * 80 + exp_word)});
                chk("req_base", {31'd0, mem_req_b}, 32'd1);
                if (exp_line == 0 && exp_word == 16) chk("wrap16", {16'd0, mem_addr_b}, 32'd0);
                last_addr = mem_addr;
                exp_word++;
                if (exp_word == 80) begin
                    exp_word = 0;
                    exp_line++;
                end
            end else begin
                wcnt--;
            end
        end else begin
            wcnt = -1;
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0; mem_ack = 1'b0; mem_rdata = 8'd0; wcnt = -1; acks = 0;
        exp_line = 0; exp_word = 0; enable = 1'b1; hc = 10'd0; vc = 10'd0;
        repeat (2) @(posedge px_clk);
        #1;
        chk("rst_timing_en", {31'd0, timing_en}, 32'd1);
        chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
        chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
        chk("rst_pix", {28'd0, pix}, 32'd0);
        chk("rst_pix_active", {31'd0, pix_active}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        reset_n = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        slow = 1'b0; pix_chk = 1'b0; last_addr = 16'd0;
        do_reset();

        // Frame start fetches source line 0 with short random latencies
        for (int i = 0; i < 1000 && acks < 80; i++) tick();
        chk("line0_acks", acks, 80);
        chk("line0_last_addr", {16'd0, last_addr}, 32'h004F);
        chk("line0_req_low", {31'd0, mem_req}, 32'd0);

        // Display lines 40..44 across two swaps; line 2 fetch follows the 43->44 swap
        hc = 10'd700; vc = 10'd39; pix_chk = 1'b1;
        for (int i = 0; i < 6000 && vc != 10'd45; i++) tick();
        chk("reach_vc45", {22'd0, vc}, 32'd45);
        chk("lines012_acks", acks, 240);
        chk("no_underrun", {31'd0, underrun}, 32'd0);
        pix_chk = 1'b0;

        // Reset while waiting for an ack
        do_reset();
        for (int i = 0; i < 30; i++) tick();
        chk("req_mid_fetch", {31'd0, mem_req}, 32'd1);
        #2 reset_n = 1'b0;
        #1 chk("req_async_drop", {31'd0, mem_req}, 32'd0);
        do_reset();
        for (int i = 0; i < 400 && acks < 3; i++) tick();
        chk("refetch_acks", acks, 3);

        // Slow memory: the first swap arrives before line 0 is complete
        do_reset();
        slow = 1'b1;
        for (int i = 0; i < 300; i++) tick();
        chk("slow_no_underrun", {31'd0, underrun}, 32'd0);
        hc = 10'd825; vc = 10'd39;
`ifdef VGA_UNDERRUN_STALL_EN
        for (int i = 0; i < 12000 && !(vc == 10'd40 && hc > 10'd4); i++) begin
            tick();
            chk("te_stall", {31'd0, timing_en},
                (hc == 10'd831 && vc == 10'd39 && acks < 80) ? 32'd0 : 32'd1);
        end
        chk("stall_released", {22'd0, vc}, 32'd40);
        chk("stall_acks", acks, 80);
`else
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("te_const", {31'd0, timing_en}, 32'd1);
        end
        chk("vc_advanced", {22'd0, vc}, 32'd40);
`endif
        chk("underrun_set", {31'd0, underrun}, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
